// File: rtl/pcm_mem_arbiter.sv
// pcm_mem_arbiter
// Round-robin arbiter and sequencer sharing the single PCM on-chip memory
// slave port among NUM_CPU CPU cores. One access is in flight at a time;
// every access passes through IDLE -> ACCESS -> (WAIT) -> DONE.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   cpu_req/we/ub/lb  per-CPU request, write flag, byte enables
//   cpu_addr/wdata    packed per-CPU address / write data (CPU i = slice i)
//   cpu_rdata         registered read data, valid during the ack cycle
//   cpu_ack           one-hot, one-cycle completion pulse
//   grant_id          index of the CPU owning the memory
//   busy              high whenever the sequencer is not idle
//   mem_*             registered PCM slave controls / data, mem_readdata in
module pcm_mem_arbiter #(
    parameter int unsigned  NUM_CPU = 4,
    parameter int unsigned  ADDR_W  = 11,
    parameter int unsigned  DATA_W  = 16,
    parameter int unsigned  RD_LAT  = 2,
    localparam int unsigned PTR_W   = (NUM_CPU > 1) ? $clog2(NUM_CPU) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_CPU-1:0]         cpu_req,
    input  logic [NUM_CPU-1:0]         cpu_we,
    input  logic [NUM_CPU-1:0]         cpu_ub,
    input  logic [NUM_CPU-1:0]         cpu_lb,
    input  logic [NUM_CPU*ADDR_W-1:0]  cpu_addr,
    input  logic [NUM_CPU*DATA_W-1:0]  cpu_wdata,
    output logic [DATA_W-1:0]          cpu_rdata,
    output logic [NUM_CPU-1:0]         cpu_ack,
    output logic [PTR_W-1:0]           grant_id,
    output logic                       busy,
    output logic [ADDR_W-1:0]          mem_address,
    output logic                       mem_chipselect,
    output logic                       mem_write,
    output logic                       mem_clken,
    output logic [1:0]                 mem_byteenable,
    output logic [DATA_W-1:0]          mem_writedata,
    input  logic [DATA_W-1:0]          mem_readdata
);

    // Wide enough for RD_LAT-1 with RD_LAT up to 4.
    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_DONE   = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [PTR_W-1:0]      last_grant_q, last_grant_d;
    logic [PTR_W-1:0]      grant_id_q, grant_id_d;
    logic [CNT_W-1:0]      wait_cnt_q, wait_cnt_d;
    logic [DATA_W-1:0]     cpu_rdata_q, cpu_rdata_d;
    logic [NUM_CPU-1:0]    cpu_ack_q, cpu_ack_d;
    logic                  busy_q, busy_d;
    logic [ADDR_W-1:0]     mem_address_q, mem_address_d;
    logic                  mem_chipselect_q, mem_chipselect_d;
    logic                  mem_write_q, mem_write_d;
    logic                  mem_clken_q, mem_clken_d;
    logic [1:0]            mem_byteenable_q, mem_byteenable_d;
    logic [DATA_W-1:0]     mem_writedata_q, mem_writedata_d;

    logic [ADDR_W-1:0]     addr_arr  [NUM_CPU];
    logic [DATA_W-1:0]     wdata_arr [NUM_CPU];

    logic                  req_found_c;
    logic [PTR_W-1:0]      req_sel_c;
    logic [PTR_W-1:0]      cand_c;

    // Unpack the per-CPU address and write-data buses.
    for (genvar g = 0; g < NUM_CPU; g++) begin : g_unpack
        assign addr_arr[g]  = cpu_addr[g*ADDR_W +: ADDR_W];
        assign wdata_arr[g] = cpu_wdata[g*DATA_W +: DATA_W];
    end

    // Round-robin search starting just after the last granted CPU.
    always_comb begin
        req_found_c = 1'b0;
        req_sel_c   = '0;
        cand_c      = '0;
        for (int unsigned k = 1; k <= NUM_CPU; k++) begin
            cand_c = PTR_W'((32'(last_grant_q) + k) % NUM_CPU);
            if (!req_found_c && cpu_req[cand_c]) begin
                req_found_c = 1'b1;
                req_sel_c   = cand_c;
            end
        end
    end

    // Next state and next registered outputs; outputs reflect the state being entered.
    always_comb begin
        state_d          = state_q;
        last_grant_d     = last_grant_q;
        grant_id_d       = grant_id_q;
        wait_cnt_d       = wait_cnt_q;
        cpu_rdata_d      = cpu_rdata_q;
        cpu_ack_d        = '0;
        mem_address_d    = mem_address_q;
        mem_writedata_d  = mem_writedata_q;
        mem_byteenable_d = mem_byteenable_q;
        mem_chipselect_d = 1'b0;
        mem_write_d      = 1'b0;
        mem_clken_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_found_c) begin
                    state_d          = S_ACCESS;
                    grant_id_d       = req_sel_c;
                    last_grant_d     = req_sel_c;
                    mem_address_d    = addr_arr[req_sel_c];
                    mem_writedata_d  = wdata_arr[req_sel_c];
                    // Reads always fetch the full word.
                    mem_byteenable_d = cpu_we[req_sel_c] ?
                                       {cpu_ub[req_sel_c], cpu_lb[req_sel_c]} : 2'b11;
                    mem_chipselect_d = 1'b1;
                    mem_clken_d      = 1'b1;
                    mem_write_d      = cpu_we[req_sel_c];
                end
            end
            S_ACCESS: begin
                wait_cnt_d = '0;
                if (mem_write_q) begin
                    state_d               = S_DONE;
                    cpu_ack_d[grant_id_q] = 1'b1;
                end else begin
                    state_d     = S_WAIT;
                    mem_clken_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (wait_cnt_q == CNT_W'(RD_LAT - 1)) begin
                    cpu_rdata_d           = mem_readdata;
                    state_d               = S_DONE;
                    cpu_ack_d[grant_id_q] = 1'b1;
                end else begin
                    wait_cnt_d  = wait_cnt_q + CNT_W'(1);
                    mem_clken_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; reset abandons any access in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= S_IDLE;
            last_grant_q     <= PTR_W'(NUM_CPU - 1);
            grant_id_q       <= '0;
            wait_cnt_q       <= '0;
            cpu_rdata_q      <= '0;
            cpu_ack_q        <= '0;
            busy_q           <= 1'b0;
            mem_address_q    <= '0;
            mem_chipselect_q <= 1'b0;
            mem_write_q      <= 1'b0;
            mem_clken_q      <= 1'b0;
            mem_byteenable_q <= '0;
            mem_writedata_q  <= '0;
        end else begin
            state_q          <= state_d;
            last_grant_q     <= last_grant_d;
            grant_id_q       <= grant_id_d;
            wait_cnt_q       <= wait_cnt_d;
            cpu_rdata_q      <= cpu_rdata_d;
            cpu_ack_q        <= cpu_ack_d;
            busy_q           <= busy_d;
            mem_address_q    <= mem_address_d;
            mem_chipselect_q <= mem_chipselect_d;
            mem_write_q      <= mem_write_d;
            mem_clken_q      <= mem_clken_d;
            mem_byteenable_q <= mem_byteenable_d;
            mem_writedata_q  <= mem_writedata_d;
        end
    end

    assign cpu_rdata      = cpu_rdata_q;
    assign cpu_ack        = cpu_ack_q;
    assign grant_id       = grant_id_q;
    assign busy           = busy_q;
    assign mem_address    = mem_address_q;
    assign mem_chipselect = mem_chipselect_q;
    assign mem_write      = mem_write_q;
    assign mem_clken      = mem_clken_q;
    assign mem_byteenable = mem_byteenable_q;
    assign mem_writedata  = mem_writedata_q;

endmodule

// File: tb/tb_pcm_mem_arbiter.sv
// Testbench for pcm_mem_arbiter: directed scenarios against a small PCM
// memory model with two cycles of read latency.
module tb_pcm_mem_arbiter;

    localparam int unsigned NUM_CPU = 4;
    localparam int unsigned ADDR_W  = 11;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned RD_LAT  = 2;

    logic                      clk;
    logic                      reset;
    logic [NUM_CPU-1:0]        cpu_req;
    logic [NUM_CPU-1:0]        cpu_we;
    logic [NUM_CPU-1:0]        cpu_ub;
    logic [NUM_CPU-1:0]        cpu_lb;
    logic [NUM_CPU*ADDR_W-1:0] cpu_addr;
    logic [NUM_CPU*DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0]         cpu_rdata;
    logic [NUM_CPU-1:0]        cpu_ack;
    logic [1:0]                grant_id;
    logic                      busy;
    logic [ADDR_W-1:0]         mem_address;
    logic                      mem_chipselect;
    logic                      mem_write;
    logic                      mem_clken;
    logic [1:0]                mem_byteenable;
    logic [DATA_W-1:0]         mem_writedata;
    logic [DATA_W-1:0]         mem_readdata;

    logic [ADDR_W-1:0]         a_addr  [NUM_CPU];
    logic [DATA_W-1:0]         a_wdata [NUM_CPU];

    int unsigned               n_checks;
    int unsigned               n_fail;
    int unsigned               cyc;
    logic [DATA_W-1:0]         last_rd;

    // Memory model
    logic [DATA_W-1:0]         mem_arr [2048];
    logic [DATA_W-1:0]         rd_pipe0;
    logic [DATA_W-1:0]         rd_pipe1;

    for (genvar g = 0; g < NUM_CPU; g++) begin : g_pack
        assign cpu_addr[g*ADDR_W +: ADDR_W]  = a_addr[g];
        assign cpu_wdata[g*DATA_W +: DATA_W] = a_wdata[g];
    end

    pcm_mem_arbiter #(
        .NUM_CPU (NUM_CPU),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .RD_LAT  (RD_LAT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .cpu_req        (cpu_req),
        .cpu_we         (cpu_we),
        .cpu_ub         (cpu_ub),
        .cpu_lb         (cpu_lb),
        .cpu_addr       (cpu_addr),
        .cpu_wdata      (cpu_wdata),
        .cpu_rdata      (cpu_rdata),
        .cpu_ack        (cpu_ack),
        .grant_id       (grant_id),
        .busy           (busy),
        .mem_address    (mem_address),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_clken      (mem_clken),
        .mem_byteenable (mem_byteenable),
        .mem_writedata  (mem_writedata),
        .mem_readdata   (mem_readdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Read data becomes valid RD_LAT(=2) cycles after the chipselect cycle.
    always @(posedge clk) begin
        if (mem_chipselect && mem_write) begin
            if (mem_byteenable[1]) mem_arr[mem_address][15:8] <= mem_writedata[15:8];
            if (mem_byteenable[0]) mem_arr[mem_address][7:0]  <= mem_writedata[7:0];
        end
        if (mem_chipselect && !mem_write) rd_pipe0 <= mem_arr[mem_address];
        rd_pipe1 <= rd_pipe0;
    end
    assign mem_readdata = rd_pipe1;

    // One complete access by a single CPU with cycle-exact checks.
    task automatic single_access(input logic [1:0] id, input logic we, input logic ub,
                                 input logic lb, input logic [ADDR_W-1:0] addr,
                                 input logic [DATA_W-1:0] wd, input logic [1:0] exp_be,
                                 input logic [DATA_W-1:0] exp_rd, input string tag);
        int                 lat;
        logic [NUM_CPU-1:0] exp_ack;
        logic [NUM_CPU-1:0] want_ack;
        logic [DATA_W-1:0]  want_rd;
        lat     = we ? 2 : 2 + int'(RD_LAT);
        exp_ack = 4'b0001 << id;
        want_rd = we ? last_rd : exp_rd;
        @(posedge clk); #1;
        cpu_we[id]  = we;
        cpu_ub[id]  = ub;
        cpu_lb[id]  = lb;
        a_addr[id]  = addr;
        a_wdata[id] = wd;
        cpu_req[id] = 1'b1;
        for (int c = 0; c <= lat; c++) begin
            @(negedge clk);
            if (c == 0) begin
                n_checks++;
                if (busy !== 1'b0 || mem_chipselect !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s_idle: busy=%b cs=%b want busy=0 cs=0", tag, busy, mem_chipselect);
                end
            end else if (c == 1) begin
                n_checks++;
                if ({mem_chipselect, mem_write, mem_clken} !== {1'b1, we, 1'b1}) begin
                    n_fail++;
                    $display("FAIL %s_ctrl: cs/we/clken=%b want %b", tag,
                             {mem_chipselect, mem_write, mem_clken}, {1'b1, we, 1'b1});
                end
                n_checks++;
                if (mem_address !== addr || mem_byteenable !== exp_be) begin
                    n_fail++;
                    $display("FAIL %s_addr_be: addr=%h be=%b want addr=%h be=%b", tag,
                             mem_address, mem_byteenable, addr, exp_be);
                end
                n_checks++;
                if (grant_id !== id) begin
                    n_fail++;
                    $display("FAIL %s_grant: got %0d want %0d", tag, grant_id, id);
                end
                if (we) begin
                    n_checks++;
                    if (mem_writedata !== wd) begin
                        n_fail++;
                        $display("FAIL %s_wdata: got %h want %h", tag, mem_writedata, wd);
                    end
                end
            end else if (c < lat) begin
                n_checks++;
                if ({mem_chipselect, mem_clken} !== 2'b01 || mem_address !== addr) begin
                    n_fail++;
                    $display("FAIL %s_wait: cs=%b clken=%b addr=%h want cs=0 clken=1 addr=%h",
                             tag, mem_chipselect, mem_clken, mem_address, addr);
                end
            end
            if (c > 0) begin
                want_ack = (c == lat) ? exp_ack : 4'b0000;
                n_checks++;
                if (cpu_ack !== want_ack) begin
                    n_fail++;
                    $display("FAIL %s_ack_c%0d: got %b want %b", tag, c, cpu_ack, want_ack);
                end
                n_checks++;
                if (busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s_busy_c%0d: got %b want 1", tag, c, busy);
                end
            end
        end
        n_checks++;
        if (cpu_rdata !== want_rd) begin
            n_fail++;
            $display("FAIL %s_rdata: got %h want %h", tag, cpu_rdata, want_rd);
        end
        n_checks++;
        if (mem_clken !== 1'b0 || mem_chipselect !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_done_ctrl: clken=%b cs=%b want 0 0", tag, mem_clken, mem_chipselect);
        end
        @(posedge clk); #1;
        cpu_req[id] = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || cpu_ack !== 4'b0000) begin
            n_fail++;
            $display("FAIL %s_after: busy=%b ack=%b want 0 0000", tag, busy, cpu_ack);
        end
        if (!we) last_rd = exp_rd;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (cpu_ack !== 4'b0000 || busy !== 1'b0 || grant_id !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_status: ack=%b busy=%b grant=%0d want 0000 0 0", cpu_ack, busy, grant_id);
        end
        n_checks++;
        if ({mem_chipselect, mem_write, mem_clken, mem_byteenable} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_mem_ctrl: got %b want 00000",
                     {mem_chipselect, mem_write, mem_clken, mem_byteenable});
        end
        n_checks++;
        if (mem_address !== '0 || mem_writedata !== '0 || cpu_rdata !== '0) begin
            n_fail++;
            $display("FAIL reset_data: addr=%h wdata=%h rdata=%h want 0", mem_address, mem_writedata, cpu_rdata);
        end
        @(posedge clk); #1;
        reset   = 1'b0;
        last_rd = '0;
    endtask

    task automatic test_single_write();
        single_access(2'd1, 1'b1, 1'b1, 1'b1, 11'h155, 16'hBEEF, 2'b11, 16'h0000, "wr1");
        single_access(2'd0, 1'b0, 1'b1, 1'b1, 11'h155, 16'h0000, 2'b11, 16'hBEEF, "rd0");
    endtask

    task automatic test_read_latency();
        single_access(2'd2, 1'b1, 1'b1, 1'b1, 11'h0A0, 16'h1234, 2'b11, 16'h0000, "wr2");
        single_access(2'd2, 1'b0, 1'b0, 1'b0, 11'h0A0, 16'h0000, 2'b11, 16'h1234, "rdlat");
    endtask

    task automatic test_four_reads();
        int unsigned       start_cyc;
        int unsigned       prev_cyc;
        bit                got;
        logic [DATA_W-1:0] exp_data [4];
        exp_data = '{16'hBEEF, 16'h1234, 16'hBEEF, 16'h1234};
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cpu_we[2'(i)]  = 1'b0;
            a_addr[2'(i)]  = (i % 2 == 0) ? 11'h155 : 11'h0A0;
            cpu_req[2'(i)] = 1'b1;
        end
        start_cyc = cyc;
        prev_cyc  = cyc;
        for (int k = 0; k < 4; k++) begin
            got = 1'b0;
            for (int t = 0; t < 20 && !got; t++) begin
                @(negedge clk);
                n_checks++;
                if ($countones(cpu_ack) > 1) begin
                    n_fail++;
                    $display("FAIL four_onehot: ack=%b want at most one bit", cpu_ack);
                end
                got = (cpu_ack != 4'b0000);
            end
            n_checks++;
            if (!got) begin
                n_fail++;
                $display("FAIL four_timeout: no ack for access %0d within 20 cycles", k);
            end
            n_checks++;
            if (cpu_ack !== (4'b0001 << k) || grant_id !== 2'(k)) begin
                n_fail++;
                $display("FAIL four_order: ack=%b grant=%0d want ack=%b grant=%0d",
                         cpu_ack, grant_id, 4'b0001 << k, k);
            end
            n_checks++;
            if (cpu_rdata !== exp_data[k]) begin
                n_fail++;
                $display("FAIL four_rdata: got %h want %h", cpu_rdata, exp_data[k]);
            end
            n_checks++;
            if ((k == 0 && cyc - start_cyc != 4) || (k > 0 && cyc - prev_cyc != 5)) begin
                n_fail++;
                $display("FAIL four_spacing: access %0d at +%0d cycles (from start %0d) want %0d",
                         k, cyc - prev_cyc, cyc - start_cyc, (k == 0) ? 4 : 5);
            end
            prev_cyc = cyc;
            @(posedge clk); #1;
            cpu_req[2'(k)] = 1'b0;
        end
        last_rd = 16'h1234;
    endtask

    task automatic test_fairness();
        int unsigned prev_cyc;
        bit          got;
        logic [1:0]  ord [4];
        ord = '{2'd0, 2'd2, 2'd0, 2'd2};
        @(posedge clk); #1;
        cpu_we[0] = 1'b1; cpu_ub[0] = 1'b1; cpu_lb[0] = 1'b1;
        a_addr[0] = 11'h200; a_wdata[0] = 16'h0A0A;
        cpu_we[2] = 1'b1; cpu_ub[2] = 1'b1; cpu_lb[2] = 1'b1;
        a_addr[2] = 11'h201; a_wdata[2] = 16'h2020;
        cpu_req   = 4'b0101;
        prev_cyc  = cyc;
        for (int k = 0; k < 4; k++) begin
            got = 1'b0;
            for (int t = 0; t < 10 && !got; t++) begin
                @(negedge clk);
                got = (cpu_ack != 4'b0000);
            end
            n_checks++;
            if (!got) begin
                n_fail++;
                $display("FAIL fair_timeout: no ack for grant %0d within 10 cycles", k);
            end
            n_checks++;
            if (cpu_ack !== (4'b0001 << ord[k]) || grant_id !== ord[k]) begin
                n_fail++;
                $display("FAIL fair_order_%0d: ack=%b grant=%0d want grant=%0d", k, cpu_ack, grant_id, ord[k]);
            end
            n_checks++;
            if ((k == 0 && cyc - prev_cyc != 2) || (k > 0 && cyc - prev_cyc != 3)) begin
                n_fail++;
                $display("FAIL fair_spacing_%0d: got %0d cycles want %0d", k, cyc - prev_cyc, (k == 0) ? 2 : 3);
            end
            n_checks++;
            if (cpu_rdata !== last_rd) begin
                n_fail++;
                $display("FAIL fair_rdata_hold: got %h want %h", cpu_rdata, last_rd);
            end
            prev_cyc = cyc;
        end
        @(posedge clk); #1;
        cpu_req = 4'b0000;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL fair_idle: busy=%b want 0", busy);
        end
    endtask

    task automatic test_byte_lanes();
        single_access(2'd3, 1'b1, 1'b0, 1'b1, 11'h155, 16'h00AA, 2'b01, 16'h0000, "lane_lo");
        single_access(2'd3, 1'b1, 1'b0, 1'b0, 11'h155, 16'h1111, 2'b00, 16'h0000, "lane_none");
        single_access(2'd3, 1'b0, 1'b0, 1'b0, 11'h155, 16'h0000, 2'b11, 16'hBEAA, "lane_rd");
    endtask

    task automatic test_reset_mid_read();
        int unsigned prev_cyc;
        bit          got;
        @(posedge clk); #1;
        cpu_we[1] = 1'b0; a_addr[1] = 11'h0A0; cpu_req[1] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if ({mem_chipselect, mem_clken, busy} !== 3'b011) begin
            n_fail++;
            $display("FAIL rst_inwait: cs/clken/busy=%b want 011", {mem_chipselect, mem_clken, busy});
        end
        reset      = 1'b1;
        cpu_req[1] = 1'b0;
        #1;
        n_checks++;
        if ({cpu_ack, busy, grant_id, mem_chipselect, mem_write, mem_clken, mem_byteenable} !== 12'b0) begin
            n_fail++;
            $display("FAIL rst_async_ctrl: got %b want all zero",
                     {cpu_ack, busy, grant_id, mem_chipselect, mem_write, mem_clken, mem_byteenable});
        end
        n_checks++;
        if (mem_address !== '0 || mem_writedata !== '0 || cpu_rdata !== '0) begin
            n_fail++;
            $display("FAIL rst_async_data: addr=%h wdata=%h rdata=%h want 0", mem_address, mem_writedata, cpu_rdata);
        end
        @(posedge clk); #1;
        reset   = 1'b0;
        last_rd = '0;
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            n_checks++;
            if (cpu_ack !== 4'b0000 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_no_ack_%0d: ack=%b busy=%b want 0000 0", t, cpu_ack, busy);
            end
        end
        single_access(2'd2, 1'b0, 1'b0, 1'b0, 11'h0A0, 16'h0000, 2'b11, 16'h1234, "rst_cpu2");
        // Tie between CPU0 and CPU2: CPU0 first.
        @(posedge clk); #1;
        cpu_we[0] = 1'b0; a_addr[0] = 11'h155;
        cpu_we[2] = 1'b0; a_addr[2] = 11'h0A0;
        cpu_req   = 4'b0101;
        prev_cyc  = cyc;
        for (int k = 0; k < 2; k++) begin
            got = 1'b0;
            for (int t = 0; t < 12 && !got; t++) begin
                @(negedge clk);
                got = (cpu_ack != 4'b0000);
            end
            n_checks++;
            if (!got) begin
                n_fail++;
                $display("FAIL tie_timeout: no ack %0d within 12 cycles", k);
            end
            n_checks++;
            if (cpu_ack !== ((k == 0) ? 4'b0001 : 4'b0100)) begin
                n_fail++;
                $display("FAIL tie_order_%0d: ack=%b want %b", k, cpu_ack, (k == 0) ? 4'b0001 : 4'b0100);
            end
            n_checks++;
            if (cpu_rdata !== ((k == 0) ? 16'hBEAA : 16'h1234)) begin
                n_fail++;
                $display("FAIL tie_rdata_%0d: got %h want %h", k, cpu_rdata, (k == 0) ? 16'hBEAA : 16'h1234);
            end
            n_checks++;
            if ((k == 0 && cyc - prev_cyc != 4) || (k == 1 && cyc - prev_cyc != 5)) begin
                n_fail++;
                $display("FAIL tie_spacing_%0d: got %0d cycles want %0d", k, cyc - prev_cyc, (k == 0) ? 4 : 5);
            end
            prev_cyc = cyc;
            @(posedge clk); #1;
            cpu_req = (k == 0) ? 4'b0100 : 4'b0000;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        clk      = 1'b0;
        reset    = 1'b1;
        cyc      = 0;
        n_checks = 0;
        n_fail   = 0;
        last_rd  = '0;
        cpu_req  = '0;
        cpu_we   = '0;
        cpu_ub   = '0;
        cpu_lb   = '0;
        for (int i = 0; i < 4; i++) begin
            a_addr[2'(i)]  = '0;
            a_wdata[2'(i)] = '0;
        end
        test_reset();
        test_single_write();
        test_read_latency();
        test_four_reads();
        test_fairness();
        test_byte_lanes();
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
